// File: rtl/router_pkg.sv
// Shared types and constants for the mesh router and its network interface.
package router_pkg;

  // Coordinate field width and packet length field width
  localparam int CW   = 4;
  localparam int LENW = 8;

  // Header field offsets, counted down from the flit MSB (field MSB = n-1-offset)
  localparam int HDR_DSTX_OFS = 0;
  localparam int HDR_DSTY_OFS = CW;
  localparam int HDR_SRCX_OFS = 2 * CW;
  localparam int HDR_SRCY_OFS = 3 * CW;
  // Length field sits at the bottom of the flit
  localparam int HDR_LEN_LSB  = 0;

  // Injector control states
  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } inj_state_t;

  // Header contents independent of flit width; zero padding is added on formatting
  typedef struct packed {
    logic [CW-1:0]   dstx;
    logic [CW-1:0]   dsty;
    logic [CW-1:0]   srcx;
    logic [CW-1:0]   srcy;
    logic [LENW-1:0] len;
  } noc_hdr_t;

endpackage

// File: rtl/inj_fifo.sv
// Payload buffer for the injector: synchronous FIFO with show-ahead head word.
// A full FIFO refuses pushes even when a pop happens in the same cycle.
module inj_fifo #(
  parameter int n     = 32,
  parameter int depth = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [n-1:0] push_data,
  input  logic         pop,
  output logic [n-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW   = $clog2(depth);
  localparam int CNTW = AW + 1;

  logic [n-1:0]    mem [depth];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign full       = (count == CNTW'(depth));
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];

  // Storage array; not reset since the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_injector.sv
// Network-interface injection stage: turns a send command plus buffered payload
// into a header flit followed by len payload flits toward the local router port.
module noc_injector
  import router_pkg::*;
#(
  parameter int n     = 32,
  parameter int srcx  = 0,
  parameter int srcy  = 0,
  parameter int depth = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CW-1:0]   cmd_dstx,
  input  logic [CW-1:0]   cmd_dsty,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [n-1:0]    wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n-1:0]    out_data,
  output logic            out_last
);

  localparam logic [CW-1:0] SRCX_F = CW'(srcx);
  localparam logic [CW-1:0] SRCY_F = CW'(srcy);

  inj_state_t      state_q;
  inj_state_t      state_d;
  noc_hdr_t        hdr_q;
  logic [LENW-1:0] rem_q;
  logic [n-1:0]    hdr_word;
  logic [n-1:0]    fifo_head;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_pop;

  inj_fifo #(
    .n     (n),
    .depth (depth)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wr_valid),
    .push_ready (wr_ready),
    .push_data  (wr_data),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Place the latched header fields into a full-width flit, zero elsewhere
  always_comb begin
    hdr_word = '0;
    hdr_word[n-1-HDR_DSTX_OFS -: CW]        = hdr_q.dstx;
    hdr_word[n-1-HDR_DSTY_OFS -: CW]        = hdr_q.dsty;
    hdr_word[n-1-HDR_SRCX_OFS -: CW]        = hdr_q.srcx;
    hdr_word[n-1-HDR_SRCY_OFS -: CW]        = hdr_q.srcy;
    hdr_word[HDR_LEN_LSB +: LENW]           = hdr_q.len;
  end

  // Next state, handshake outputs and FIFO pop; payload flits come straight off the FIFO head
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = HDR;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
        out_last  = (hdr_q.len == '0);
        if (out_ready) begin
          state_d = (hdr_q.len == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        out_valid = !fifo_empty;
        out_data  = fifo_head;
        out_last  = (rem_q == LENW'(1));
        if (out_ready && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (rem_q == LENW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, command latch and remaining-flit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        hdr_q.dstx <= cmd_dstx;
        hdr_q.dsty <= cmd_dsty;
        hdr_q.srcx <= SRCX_F;
        hdr_q.srcy <= SRCY_F;
        hdr_q.len  <= cmd_len;
      end
      if (state_q == HDR && out_ready) begin
        rem_q <= hdr_q.len;
      end else if (fifo_pop) begin
        rem_q <= rem_q - LENW'(1);
      end
    end
  end

  // Full flag is exported as wr_ready by the FIFO; kept here for observability
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_noc_injector.sv
// Directed self-checking bench for noc_injector (n=32, depth=4, source 0,0).
module tb_noc_injector;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dstx;
  logic [3:0]  cmd_dsty;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  noc_injector #(
    .n     (32),
    .srcx  (0),
    .srcy  (0),
    .depth (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dstx  (cmd_dstx),
    .cmd_dsty  (cmd_dsty),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge and settle just after it; inputs are driven here too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_dstx = '0; cmd_dsty = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got cr=%b wr=%b ov=%b ol=%b od=%h expected 1 1 0 0 00000000",
               cmd_ready, wr_ready, out_valid, out_last, out_data);
    end
  endtask

  task automatic test_header_only();
    cmd_valid = 1'b1; cmd_dstx = 4'd1; cmd_dsty = 4'd1; cmd_len = 8'd0; out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1100_0000 || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hdr_only_flit: got v=%b d=%h l=%b expected 1 11000000 1", out_valid, out_data, out_last);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hdr_only_idle: got cr=%b ov=%b expected 1 0", cmd_ready, out_valid);
    end
  endtask

  task automatic test_prefilled();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h1000_0003; exp_d[1] = 32'hA; exp_d[2] = 32'hB; exp_d[3] = 32'hC;
    out_ready = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = exp_d[i+1];
      step();
    end
    wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dstx = 4'd1; cmd_dsty = 4'd0; cmd_len = 8'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL prefill_flit%0d: got v=%b d=%h l=%b expected 1 %h %b",
                 i, out_valid, out_data, out_last, exp_d[i], (i == 3));
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prefill_idle: got ov=%b cr=%b expected 0 1", out_valid, cmd_ready);
    end
  endtask

  task automatic test_late_payload();
    logic        exp_v [10];
    logic [31:0] exp_d [10];
    logic        exp_l [10];
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = '0; exp_l[i] = 1'b0;
    end
    exp_v[1] = 1'b1; exp_d[1] = 32'h1100_0002;
    exp_v[5] = 1'b1; exp_d[5] = 32'h11;
    exp_v[8] = 1'b1; exp_d[8] = 32'h22; exp_l[8] = 1'b1;
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_dstx = 4'd1; cmd_dsty = 4'd1; cmd_len = 8'd2;
    for (int i = 1; i <= 9; i++) begin
      step();
      cmd_valid = 1'b0;
      wr_valid  = (i == 4) || (i == 7);
      wr_data   = (i == 4) ? 32'h11 : 32'h22;
      checks++;
      if (out_valid !== exp_v[i] || (exp_v[i] && (out_data !== exp_d[i] || out_last !== exp_l[i]))) begin
        errors++;
        $display("[TB] FAIL late_cycle%0d: got v=%b d=%h l=%b expected %b %h %b",
                 i, out_valid, out_data, out_last, exp_v[i], exp_d[i], exp_l[i]);
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL late_idle: got cr=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_full();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'hF0 + i;
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_dstx = 4'd2; cmd_dsty = 4'd3; cmd_len = 8'd5;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_ready_before%0d: got %b expected 1", i, wr_ready);
      end
      wr_data = w[i];
      step();
      cmd_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h2300_0005) begin
        errors++;
        $display("[TB] FAIL full_hdr_hold%0d: got v=%b d=%h expected 1 23000005", i, out_valid, out_data);
      end
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_after4: got wr_ready=%b expected 0", wr_ready);
    end
    wr_data = w[4];
    out_ready = 1'b1;
    step();
    checks++;
    if (wr_ready !== 1'b0 || out_data !== w[0]) begin
      errors++;
      $display("[TB] FAIL full_hdr_sent: got wr=%b d=%h expected 0 %h", wr_ready, out_data, w[0]);
    end
    step();
    checks++;
    if (wr_ready !== 1'b1 || out_data !== w[1]) begin
      errors++;
      $display("[TB] FAIL full_pop_refuse: got wr=%b d=%h expected 1 %h", wr_ready, out_data, w[1]);
    end
    out_ready = 1'b0;
    step();
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_push_late: got wr_ready=%b expected 0", wr_ready);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL full_drain%0d: got v=%b d=%h l=%b expected 1 %h %b",
                 i, out_valid, out_data, out_last, w[i], (i == 4));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_idle: got ov=%b cr=%b expected 0 1", out_valid, cmd_ready);
    end
  endtask

  task automatic test_stall();
    int          pushed = 0;
    int          got = 0;
    int          cyc = 0;
    bit          stall = 1'b0;
    bit          r;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;
    cmd_valid = 1'b1; cmd_dstx = 4'd0; cmd_dsty = 4'd1; cmd_len = 8'd8; out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0100_0008 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_hdr: got v=%b d=%h l=%b expected 1 01000008 0", out_valid, out_data, out_last);
    end
    step();
    while (got < 8 && cyc < 200) begin
      cyc++;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          errors++;
          $display("[TB] FAIL stall_hold: got v=%b d=%h l=%b expected 1 %h %b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== 32'h100 + got || out_last !== (got == 7)) begin
          errors++;
          $display("[TB] FAIL stall_word%0d: got d=%h l=%b expected %h %b",
                   got, out_data, out_last, 32'h100 + got, (got == 7));
        end
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        got++;
        stall = 1'b0;
      end else if (out_valid === 1'b1) begin
        stall = 1'b1;
        held_d = out_data;
        held_l = out_last;
      end else begin
        stall = 1'b0;
      end
      wr_valid = (pushed < 8);
      wr_data  = 32'h100 + pushed;
      if (wr_valid && wr_ready === 1'b1) pushed++;
      step();
    end
    wr_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got !== 8) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d words expected 8 (timeout)", got);
    end
    checks++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_idle: got cr=%b ov=%b expected 1 0", cmd_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'h50 + i;
      step();
    end
    wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dstx = 4'd4; cmd_dsty = 4'd4; cmd_len = 8'd4;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h50) begin
      errors++;
      $display("[TB] FAIL rstmid_first: got v=%b d=%h expected 1 00000050", out_valid, out_data);
    end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_state: got ov=%b cr=%b wr=%b d=%h expected 0 1 1 00000000",
               out_valid, cmd_ready, wr_ready, out_data);
    end
    cmd_valid = 1'b1; cmd_dstx = 4'd3; cmd_dsty = 4'd2; cmd_len = 8'd1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3200_0001 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_hdr: got v=%b d=%h l=%b expected 1 32000001 0", out_valid, out_data, out_last);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_fifo_empty: got ov=%b expected 0", out_valid);
    end
    wr_valid = 1'b1; wr_data = 32'h77;
    step();
    wr_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_payload: got v=%b d=%h l=%b expected 1 00000077 1", out_valid, out_data, out_last);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_idle: got ov=%b cr=%b expected 0 1", out_valid, cmd_ready);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_header_only();
    test_prefilled();
    test_late_payload();
    test_full();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_injector.md
# noc_injector

Network-interface injection stage sitting directly upstream of each mesh router's processor-input port. Accepts a send command (destination, length) and a stream of payload words from the local processing element. Emits one header flit followed by `len` payload flits on a valid/ready output that drives the router's local input. Buffers payload in a small synchronous FIFO so the PE can pre-load data while a previous packet drains.

## Interface
- `n`, 32, flit/data width; must be ≥ 24
- `srcx`, 0, this node's X coordinate, inserted into header
- `srcy`, 0, this node's Y coordinate, inserted into header
- `depth`, 4, payload FIFO depth in words; power of 2, ≥ 2

- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1: send command present
- `cmd_ready` out 1: command accepted when both high
- `cmd_dstx` in 4: destination X
- `cmd_dsty` in 4: destination Y
- `cmd_len` in 8: payload flit count, 0..255 (0 = header-only packet)
- `wr_valid` in 1: payload word present
- `wr_ready` out 1: FIFO not full
- `wr_data` in n: payload word
- `out_valid` out 1: flit present toward router
- `out_ready` in 1: router accepts flit
- `out_data` out n: flit
- `out_last` out 1: current flit is final flit of packet

## Operation
- Header flit layout: [n-1:n-4] dstx, [n-5:n-8] dsty, [n-9:n-12] srcx, [n-13:n-16] srcy, [7:0] len, all other bits 0.
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: `cmd_ready`=1, `out_valid`=0. On `cmd_valid`, latch dstx/dsty/len and go to HDR.
  - HDR: `out_valid`=1, `out_data`=header, `out_last`=(len==0). On `out_ready`, go to IDLE if len==0; otherwise load the remaining counter with len and go to PAYLOAD.
  - PAYLOAD: `out_valid`=FIFO not empty, `out_data`=FIFO head, `out_last`=(remaining==1). Each handshake pops the FIFO and decrements remaining. The handshake at remaining==1 goes to IDLE.
- The FIFO is independent of the FSM. Push whenever `wr_valid && wr_ready`, including during IDLE/HDR, so payload may precede the command.
- `wr_ready` = !full, with no bypass. When full, a push is refused even if a pop occurs in the same cycle. When neither full nor empty, simultaneous push and pop leaves the count unchanged.
- Pointers are log2(depth) bits wide and wrap modulo depth. The count is log2(depth)+1 bits wide.
- Once `out_valid` is asserted, `out_data`/`out_last` are held stable until `out_ready`. Valid never drops without a handshake; rst is the only exception.
- Surplus FIFO words beyond `len` stay queued and become payload of the next packet. The block does not check that FIFO contents match `len`.

## Timing
- Reset: state IDLE, FIFO empty, counters 0.
  - Outputs in the cycle after rst: `cmd_ready`=1, `wr_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset asserted mid-packet: the packet is abandoned and FIFO contents are discarded. No partial-packet recovery.
- Command accepted at cycle t: header is valid at t+1.
- A word pushed at t is poppable (visible on `out_data`) at t+1 at the earliest.
- Back-to-back packets: minimum one IDLE cycle between the last flit of one packet and the header of the next.
- With a prefilled FIFO and `out_ready` held high, a packet of len L occupies L+1 consecutive cycles.

## Structure
- Add to `router_pkg`:
  - `CW`=4 and `LENW`=8 constants
  - header field offset constants
  - `inj_state_t` enum {IDLE, HDR, PAYLOAD}
  - packed `noc_hdr_t` struct
- Sub-module `inj_fifo` (parameters `n`, `depth`): synchronous FIFO with `full`/`empty` flags and a show-ahead head output.
- `noc_injector` contains the FSM, command latch and header formatting only.

## Test plan
- Reset, then `cmd` dst=(1,1), len=0, srcx=srcy=0, `out_ready`=1 → one flit, `out_data`=0x1100_0000, `out_last`=1, then IDLE with `cmd_ready`=1.
- Push 0xA, 0xB, 0xC, then `cmd` dst=(1,0), len=3 → header 0x1000_0003, then 0xA, 0xB, 0xC on consecutive cycles; `out_last` high on 0xC only.
- `cmd` len=2 with FIFO empty; push 0x11 five cycles later and 0x22 three cycles after that → `out_valid` low while empty, flits emitted in order, `out_last` on 0x22.
- With depth=4, push 5 words while `out_ready`=0 → `wr_ready` drops after the 4th push, the 5th word is held off. One pop in the full cycle still refuses the push; the push succeeds the next cycle.
- `out_ready` toggled 1/0 randomly during len=8 → `out_data`/`out_last` stable while stalled, all 8 words delivered in order.
- Assert rst after 2 of 4 payload flits → next cycle `out_valid`=0, FIFO empty, `cmd_ready`=1. A new len=1 packet is then delivered correctly.
